// File: rtl/jk_pkg.sv
// rtl/jk_pkg.sv - JK excitation codes and encoder function shared by counter and benches
package jk_pkg;

  // {J,K} codes for each present->next bit transition; don't-cares resolved to 0
  localparam logic [1:0] EXC_HOLD0 = 2'b00;
  localparam logic [1:0] EXC_SET   = 2'b10;
  localparam logic [1:0] EXC_RESET = 2'b01;
  localparam logic [1:0] EXC_HOLD1 = 2'b00;

  // Map present state bit q and desired next bit nxt to the {J,K} pair that produces it
  function automatic logic [1:0] jk_excite(input logic q, input logic nxt);
    logic [1:0] code;
    case ({q, nxt})
      2'b00:   code = EXC_HOLD0;
      2'b01:   code = EXC_SET;
      2'b10:   code = EXC_RESET;
      default: code = EXC_HOLD1;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/jk_cell.sv
// rtl/jk_cell.sv - single JK flip-flop with synchronous active-high reset
module jk_cell (
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q
);

  // JK characteristic equation; reset bypasses J/K entirely
  always_ff @(posedge clk) begin
    if (rst) q <= 1'b0;
    else     q <= (j & ~q) | (~k & q);
  end

endmodule

// File: rtl/jk_mod_counter.sv
// rtl/jk_mod_counter.sv - modulo-M up/down counter with parallel load built from JK cells
module jk_mod_counter
  import jk_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf,
  output logic [WIDTH-1:0] jk_j,
  output logic [WIDTH-1:0] jk_k
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  // One bit wider so MODULUS == 2**WIDTH still compares correctly
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] nxt;
  logic             load_in_range;

  assign count         = q;
  assign load_in_range = ({1'b0, load_val} < MOD_EXT);

  // Desired next state; out-of-range counts fold back to 0 (up) or MAX_VAL (down)
  always_comb begin
    nxt = q;
    if (load) begin
      nxt = load_in_range ? load_val : MAX_VAL;
    end else if (en) begin
      if (up) nxt = (q >= MAX_VAL) ? '0 : q + WIDTH'(1);
      else    nxt = ((q == '0) || (q > MAX_VAL)) ? MAX_VAL : q - WIDTH'(1);
    end
  end

  // Per-bit excitation encoder feeding each JK cell
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign {jk_j[i], jk_k[i]} = jk_excite(q[i], nxt[i]);

    jk_cell u_cell (
      .clk (clk),
      .rst (rst),
      .j   (jk_j[i]),
      .k   (jk_k[i]),
      .q   (q[i])
    );
  end

  // Terminal count: high only in the cycle whose edge will wrap the count
  assign tc = ~rst & ~load & en & ((up & (q == MAX_VAL)) | (~up & (q == '0)));

  // Sticky wrap flag; a wrap in the same cycle as a clear keeps it set
  always_ff @(posedge clk) begin
    if (rst)          ovf <= 1'b0;
    else if (tc)      ovf <= 1'b1;
    else if (clr_ovf) ovf <= 1'b0;
  end

endmodule

// File: tb/tb_jk_mod_counter.sv
// tb/tb_jk_mod_counter.sv - directed self-checking bench for jk_mod_counter
module tb_jk_mod_counter;
  import jk_pkg::*;

  logic       clk = 1'b0;
  logic       rst, en, up, load, clr_ovf;
  logic [3:0] load_val;
  logic [3:0] count, jk_j, jk_k;
  logic       tc, ovf;

  int n_checks = 0;
  int n_fail   = 0;

  jk_mod_counter #(.WIDTH(4), .MODULUS(10)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .up       (up),
    .load     (load),
    .load_val (load_val),
    .clr_ovf  (clr_ovf),
    .count    (count),
    .tc       (tc),
    .ovf      (ovf),
    .jk_j     (jk_j),
    .jk_k     (jk_k)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; up = 1'b0; load = 1'b0; clr_ovf = 1'b0; load_val = 4'd0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; up = 1'b0; load = 1'b1; load_val = 4'd5; clr_ovf = 1'b0;
    tick();
    n_checks++;
    if (count !== 4'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", count); end
    n_checks++;
    if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
    load = 1'b0;
    #1;
    n_checks++;
    if (tc !== 1'b0) begin n_fail++; $display("FAIL reset_tc_gate got=%b exp=0", tc); end
    rst = 1'b0;
    #1;
    n_checks++;
    if (tc !== 1'b1) begin n_fail++; $display("FAIL reset_release_tc got=%b exp=1", tc); end
    en = 1'b0;
  endtask

  task automatic test_up_wrap();
    logic [3:0] c, n, ej, ek;
    do_reset();
    en = 1'b1; up = 1'b1;
    for (int i = 0; i < 12; i++) begin
      c = 4'(i % 10);
      n = (c == 4'd9) ? 4'd0 : c + 4'd1;
      for (int b = 0; b < 4; b++) {ej[b], ek[b]} = jk_excite(c[b], n[b]);
      #1;
      n_checks++;
      if (count !== c) begin n_fail++; $display("FAIL up_count i=%0d got=%0d exp=%0d", i, count, c); end
      n_checks++;
      if (tc !== (c == 4'd9)) begin n_fail++; $display("FAIL up_tc i=%0d got=%b exp=%b", i, tc, c == 4'd9); end
      n_checks++;
      if (jk_j !== ej || jk_k !== ek) begin
        n_fail++; $display("FAIL up_jk i=%0d got=%b/%b exp=%b/%b", i, jk_j, jk_k, ej, ek);
      end
      n_checks++;
      if ((jk_j & jk_k) !== 4'b0000) begin n_fail++; $display("FAIL up_jk_excl i=%0d got=%b exp=0000", i, jk_j & jk_k); end
      if (c == 4'd7) begin
        n_checks++;
        if (jk_j !== 4'b1000 || jk_k !== 4'b0111) begin
          n_fail++; $display("FAIL up_7to8_jk got=%b/%b exp=1000/0111", jk_j, jk_k);
        end
      end
      tick();
      n_checks++;
      if (ovf !== (i >= 9)) begin n_fail++; $display("FAIL up_ovf i=%0d got=%b exp=%b", i, ovf, i >= 9); end
    end
    en = 1'b0;
  endtask

  task automatic test_down_wrap();
    do_reset();
    en = 1'b1; up = 1'b0;
    #1;
    n_checks++;
    if (tc !== 1'b1) begin n_fail++; $display("FAIL down_tc0 got=%b exp=1", tc); end
    n_checks++;
    if (jk_j !== 4'b1001 || jk_k !== 4'b0000) begin
      n_fail++; $display("FAIL down_0to9_jk got=%b/%b exp=1001/0000", jk_j, jk_k);
    end
    tick();
    n_checks++;
    if (count !== 4'd9) begin n_fail++; $display("FAIL down_count9 got=%0d exp=9", count); end
    n_checks++;
    if (ovf !== 1'b1) begin n_fail++; $display("FAIL down_ovf got=%b exp=1", ovf); end
    n_checks++;
    if (tc !== 1'b0) begin n_fail++; $display("FAIL down_tc9 got=%b exp=0", tc); end
    n_checks++;
    if (jk_j !== 4'b0000 || jk_k !== 4'b0001) begin
      n_fail++; $display("FAIL down_9to8_jk got=%b/%b exp=0000/0001", jk_j, jk_k);
    end
    tick();
    n_checks++;
    if (count !== 4'd8) begin n_fail++; $display("FAIL down_count8 got=%0d exp=8", count); end
    en = 1'b0;
  endtask

  task automatic test_load();
    do_reset();
    load = 1'b1; load_val = 4'd13;
    tick();
    n_checks++;
    if (count !== 4'd9) begin n_fail++; $display("FAIL load_sat13 got=%0d exp=9", count); end
    load_val = 4'd5;
    tick();
    n_checks++;
    if (count !== 4'd5) begin n_fail++; $display("FAIL load_5 got=%0d exp=5", count); end
    load_val = 4'd10;
    tick();
    n_checks++;
    if (count !== 4'd9) begin n_fail++; $display("FAIL load_sat10 got=%0d exp=9", count); end
    load_val = 4'd3; en = 1'b1; up = 1'b1;
    #1;
    n_checks++;
    if (tc !== 1'b0) begin n_fail++; $display("FAIL load_tc_supp got=%b exp=0", tc); end
    n_checks++;
    if (jk_j !== 4'b0010 || jk_k !== 4'b1000) begin
      n_fail++; $display("FAIL load_9to3_jk got=%b/%b exp=0010/1000", jk_j, jk_k);
    end
    tick();
    n_checks++;
    if (count !== 4'd3) begin n_fail++; $display("FAIL load_wins got=%0d exp=3", count); end
    n_checks++;
    if (ovf !== 1'b0) begin n_fail++; $display("FAIL load_no_ovf got=%b exp=0", ovf); end
    load = 1'b0; en = 1'b0;
  endtask

  task automatic test_hold();
    do_reset();
    load = 1'b1; load_val = 4'd6;
    tick();
    load = 1'b0; en = 1'b0; up = 1'b1;
    #1;
    n_checks++;
    if (jk_j !== 4'b0000 || jk_k !== 4'b0000) begin
      n_fail++; $display("FAIL hold_jk got=%b/%b exp=0000/0000", jk_j, jk_k);
    end
    tick();
    tick();
    n_checks++;
    if (count !== 4'd6) begin n_fail++; $display("FAIL hold_count got=%0d exp=6", count); end
  endtask

  task automatic test_ovf_race();
    do_reset();
    load = 1'b1; load_val = 4'd9;
    tick();
    load = 1'b0; en = 1'b1; up = 1'b1; clr_ovf = 1'b1;
    #1;
    n_checks++;
    if (tc !== 1'b1) begin n_fail++; $display("FAIL race_tc got=%b exp=1", tc); end
    tick();
    n_checks++;
    if (ovf !== 1'b1) begin n_fail++; $display("FAIL race_set_wins got=%b exp=1", ovf); end
    n_checks++;
    if (count !== 4'd0) begin n_fail++; $display("FAIL race_count got=%0d exp=0", count); end
    en = 1'b0;
    tick();
    n_checks++;
    if (ovf !== 1'b0) begin n_fail++; $display("FAIL race_clear got=%b exp=0", ovf); end
    clr_ovf = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    load = 1'b1; load_val = 4'd9;
    tick();
    load = 1'b0; en = 1'b1; up = 1'b1;
    tick();
    load = 1'b1; load_val = 4'd6; en = 1'b0;
    tick();
    n_checks++;
    if (count !== 4'd6 || ovf !== 1'b1) begin
      n_fail++; $display("FAIL mid_setup got=%0d/%b exp=6/1", count, ovf);
    end
    rst = 1'b1; en = 1'b1; load = 1'b1; load_val = 4'd2;
    tick();
    n_checks++;
    if (count !== 4'd0) begin n_fail++; $display("FAIL mid_rst_count got=%0d exp=0", count); end
    n_checks++;
    if (ovf !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ovf got=%b exp=0", ovf); end
    rst = 1'b0; en = 1'b0; load = 1'b0;
    tick();
    tick();
    n_checks++;
    if (count !== 4'd0) begin n_fail++; $display("FAIL mid_hold got=%0d exp=0", count); end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; up = 1'b0; load = 1'b0; clr_ovf = 1'b0; load_val = 4'd0;
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_load();
    test_hold();
    test_ovf_race();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/jk_mod_counter.md
Name: jk_mod_counter

Overview:
Synchronous modulo-M up/down counter with parallel load. Each state bit is held in a JK flip-flop cell. Per-bit J/K inputs come from a JK excitation encoder that maps present state to desired next state. This is the inverse of the D-to-JK characteristic conversion already used in the codebase. It serves as the counting and timing primitive for the sequential-logic blocks, and it exposes J/K vectors so excitation can be checked directly.

Parameters:
WIDTH, 4, state width in bits; must satisfy 2**WIDTH >= MODULUS
MODULUS, 10, count range 0..MODULUS-1; must be >= 2

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
en  input  1  count enable
up  input  1  direction: 1 = increment, 0 = decrement
load  input  1  parallel load strobe
load_val  input  WIDTH  value loaded when load=1
clr_ovf  input  1  clears sticky overflow flag
count  output  WIDTH  current state, taken directly from the JK cell outputs
tc  output  1  terminal count, combinational
ovf  output  1  sticky wrap flag, registered
jk_j  output  WIDTH  J inputs currently applied to the cells
jk_k  output  WIDTH  K inputs currently applied to the cells

Behaviour:
- Interface: one clock `clk`. Reset `rst` is synchronous and active-high.
- Reset: on a clk edge with rst=1, count=0 and ovf=0. Reset dominates load, en and clr_ovf. jk_j/jk_k are not used during reset; the cells reset through their own sync-reset input.
- Priority per edge: rst > load > en > hold.
- Next-state value nxt:
  - load=1: nxt = load_val if load_val < MODULUS, else MODULUS-1 (saturate).
  - en=1, up=1: nxt = 0 if count == MODULUS-1, else count+1.
  - en=1, up=0: nxt = MODULUS-1 if count == 0, else count-1.
  - otherwise: nxt = count.
- Excitation, per bit i, is fixed and fully deterministic, with don't-cares resolved to 0:
  - 0->0: J=0, K=0
  - 0->1: J=1, K=0
  - 1->0: J=0, K=1
  - 1->1: J=0, K=0
  - Equivalently J = ~q & nxt and K = q & ~nxt. J=K=1 is never driven.
- JK cell: q <= (j & ~q) | (~k & q) on rising clk; sync reset to 0.
- jk_j/jk_k are combinational from count and the inputs. They are valid in every non-reset cycle.
- Latency: count reflects the nxt of cycle n at cycle n+1. No extra pipeline stage.
- tc = ~rst & ~load & en & ((up & count==MODULUS-1) | (~up & count==0)). tc is high exactly in the cycle before a wrap edge.
- ovf: set on any edge where tc=1; cleared on an edge where clr_ovf=1 and tc=0. If tc=1 and clr_ovf=1 in the same cycle, set wins.
- Out-of-range state is unreachable from reset. Any count >= MODULUS reached by other means moves to 0 on the next enabled up-count and to MODULUS-1 on a down-count.
- A load in the same cycle as a would-be wrap suppresses tc and does not set ovf.
- Reset mid-count takes effect at the next edge regardless of en/load.

Decomposition:
- Shared package jk_pkg holds the excitation constants EXC_HOLD0, EXC_SET, EXC_RESET and EXC_HOLD1 as 2-bit {J,K} codes. It also holds a function jk_excite(q, nxt) returning {J,K}, which benches reuse for checking.
- One natural sub-module, jk_cell: a single JK flip-flop with synchronous active-high reset. It is instantiated WIDTH times via generate.
- Top-level holds the nxt logic, excitation encoding, tc and ovf.

Test Plan:
- Up-wrap (WIDTH=4, MODULUS=10): rst, then en=1, up=1 for 12 cycles -> count 0..9,0,1; tc=1 only while count=9; ovf=1 from the wrap edge on.
- Down-wrap: rst, en=1, up=0 -> count 0,9,8; tc=1 in the count=0 cycle; jk_j=4'b1001, jk_k=4'b0000 on the 0->9 step.
- Load saturation: load=1, load_val=13 -> count=9 next cycle; load_val=5 -> count=5; load and en both high -> load wins and tc=0.
- Excitation check: at every cycle, jk_j & jk_k == 0, and {jk_j[i], jk_k[i]} == jk_excite(count[i], nxt[i]); at 7->8 up, jk_j=4'b1000 and jk_k=4'b0111.
- ovf race: count=9, en=1, up=1, clr_ovf=1 -> ovf=1 after the edge; next cycle clr_ovf=1, tc=0 -> ovf=0.
- Reset mid-operation: count=6, en=1, load=1, load_val=2, rst=1 -> count=0, ovf=0 after the edge; en=0 holds count at 0.
